// File: rtl/risc_mon_pkg.sv
// -----------------------------------------------------------------------------
// risc_mon_pkg
// Shared definitions for the RISC exit monitor:
//   - FSM state encodings (as localparams and as an enum built on them)
//   - default register-file data/address widths
//   - register indices shared with the core ($at holds the exit flag,
//     $v0 holds the first result)
// -----------------------------------------------------------------------------
package risc_mon_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_AT   = 1;
    localparam int REG_V0   = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_TOUT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE,
        S_TOUT = ST_TOUT
    } mon_state_e;

endpackage : risc_mon_pkg

// File: rtl/exit_mon_shadow.sv
// -----------------------------------------------------------------------------
// exit_mon_shadow
// Shadow register bank for NUM_RESULTS consecutive core registers starting at
// RESULT_REG. A register-file write whose address falls inside the window is
// copied into the matching entry while wr_en is high. Address 0 never matches
// because r0 is hardwired in the core.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-low; clears all entries
//   clr      in   synchronous clear of all entries (wins over writes)
//   wr_en    in   capture qualifier (monitor is running)
//   rf_we    in   register-file write enable
//   rf_waddr in   register-file write address
//   rf_wdata in   register-file write data
//   sel      in   entry select for the read mux
//   rdata    out  selected entry, 0 when sel >= NUM_RESULTS
// -----------------------------------------------------------------------------
module exit_mon_shadow
    import risc_mon_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int RESULT_REG  = REG_V0,
    parameter int NUM_RESULTS = 1,
    parameter int SEL_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] rf_waddr,
    input  logic [DATA_W-1:0] rf_wdata,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0]      shadow [NUM_RESULTS];
    logic [NUM_RESULTS-1:0] entry_we;

    always_comb begin
        entry_we = '0;
        for (int i = 0; i < NUM_RESULTS; i++) begin
            entry_we[i] = wr_en && rf_we && (rf_waddr != '0)
                          && (rf_waddr == ADDR_W'(RESULT_REG + i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
                if (entry_we[i]) begin
                    shadow[i] <= rf_wdata;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_RESULTS; i++) begin
            if (sel == SEL_W'(i)) begin
                rdata = shadow[i];
            end
        end
    end

endmodule : exit_mon_shadow

// File: rtl/risc_exit_monitor.sv
// -----------------------------------------------------------------------------
// risc_exit_monitor
// Watches the core register-file write port and detects program completion
// (SENTINEL written to FLAG_REG). Shadows the result registers, counts RUN
// cycles and raises a sticky timeout when the watchdog limit is hit.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-low
//   start    in   pulse: clear counter/shadows and enter RUN
//   rf_we    in   register-file write enable
//   rf_waddr in   register-file write address
//   rf_wdata in   register-file write data
//   res_sel  in   selects captured result (0..NUM_RESULTS-1)
//   res_data out  shadow of register RESULT_REG+res_sel
//   busy     out  monitor is in RUN
//   done     out  completion detected (held until start/reset)
//   timeout  out  watchdog expired (held until start/reset)
//   cycles   out  RUN cycles elapsed, saturating
//   halt     out  only with RISC_EXIT_MON_HALT_EN: registered core
//                 clock-enable gate, high in DONE and TOUT
//
// Build option: define RISC_EXIT_MON_HALT_EN to add the halt output.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | out of reset, waiting for start
// RUN   | program running; counting, capturing results, watching flag
// DONE  | sentinel seen; results and count frozen
// TOUT  | watchdog expired; results and count frozen
// -----------------------------------------------------------------------------
module risc_exit_monitor
    import risc_mon_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int FLAG_REG    = REG_AT,
    parameter int SENTINEL    = 1,
    parameter int RESULT_REG  = REG_V0,
    parameter int NUM_RESULTS = 1,
    parameter int SEL_W       = 3,
    parameter int TIMEOUT     = 500,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] rf_waddr,
    input  logic [DATA_W-1:0] rf_wdata,
    input  logic [SEL_W-1:0]  res_sel,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles
`ifdef RISC_EXIT_MON_HALT_EN
    ,
    output logic              halt
`endif
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    mon_state_e state_q, state_d;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       capture_en;
    logic       flag_hit;

    assign flag_hit = rf_we
                      && (rf_waddr == ADDR_W'(FLAG_REG))
                      && (rf_wdata == DATA_W'(SENTINEL));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start overrides everything, including a completion or watchdog hit on
    // the same edge: the run is restarted rather than finished.
    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        capture_en = 1'b0;
        if (start) begin
            state_d = S_RUN;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                S_RUN: begin
                    cnt_inc    = 1'b1;
                    capture_en = 1'b1;
                    if (flag_hit) begin
                        state_d = S_DONE;
                    end else if (cycles == WDOG_LAST) begin
                        state_d = S_TOUT;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || cnt_clr) begin
            cycles <= '0;
        end else if (cnt_inc && (cycles != '1)) begin
            cycles <= cycles + 1'b1;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign timeout = (state_q == S_TOUT);

`ifdef RISC_EXIT_MON_HALT_EN
    // Follows the next state so halt rises and falls on the same edge the
    // FSM enters or leaves DONE/TOUT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            halt <= 1'b0;
        end else begin
            halt <= (state_d == S_DONE) || (state_d == S_TOUT);
        end
    end
`endif

    exit_mon_shadow #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .RESULT_REG  (RESULT_REG),
        .NUM_RESULTS (NUM_RESULTS),
        .SEL_W       (SEL_W)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .clr      (start),
        .wr_en    (capture_en),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .sel      (res_sel),
        .rdata    (res_data)
    );

endmodule : risc_exit_monitor
